// File: rtl/ir_nec_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ir_nec_tx -- NEC-protocol infrared transmitter.
//
// Accepts a 32-bit word on a start/ready handshake and sends it LSB-first as an
// NEC frame: 16-unit AGC mark, 8-unit space, 32 pulse-distance bits
// (1-unit mark + 1-unit space for 0, 1-unit mark + 3-unit space for 1), then a
// 1-unit stop mark. done pulses for one cycle when the stop mark completes.
//
// Build option:
//   IR_NEC_TX_CARRIER_EN  defined  : ir_out = envelope AND carrier (bare LED).
//                         undefined: ir_out = envelope (external modulator).
//
// Parameters:
//   UNIT_CYCLES   clock cycles per NEC unit (562.5 us)
//   CARRIER_DIV   clock cycles per carrier period
//   CARRIER_HIGH  carrier high cycles per period, must be < CARRIER_DIV
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   start   in   frame request, accepted when ready=1
//   data    in   32-bit payload, captured on accept, bit 0 sent first
//   ready   out  high only while idle
//   done    out  one-cycle pulse after the stop mark
//   ir_out  out  LED drive, 1 = LED on (registered)
// -----------------------------------------------------------------------------
module ir_nec_tx #(
    parameter int UNIT_CYCLES  = 56_250,
    parameter int CARRIER_DIV  = 2_631,
    parameter int CARRIER_HIGH = 877
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data,
    output logic        ready,
    output logic        done,
    output logic        ir_out
);

    localparam int            UW        = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        AGC,
        SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP
    } state_t;

    state_t        state;
    logic [UW-1:0] unit_cnt;   // cycle within the current unit
    logic [3:0]    unit_num;   // unit within the current state
    logic [4:0]    bit_cnt;    // payload bit being sent
    logic [31:0]   shreg;      // payload, bit 0 is the current bit
    logic          env;        // registered envelope

    logic [3:0]    len_last;   // last unit index of the current state
    logic          unit_end;
    logic          state_end;
    logic          env_next;

    // A carrier period longer than its high phase is required; this empty
    // block only exists to make a bad configuration visible in the hierarchy.
    if (CARRIER_HIGH >= CARRIER_DIV) begin : g_carrier_cfg_invalid
    end

    // Length lookup and the envelope value the next edge will load. env_next
    // is computed here so the carrier logic can register ir_out in step with
    // the envelope instead of gating two flops combinationally.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        len_last = 4'd0;
        env_next = env;
        case (state)
            AGC:       len_last = 4'd15;
            SPACE:     len_last = 4'd7;
            BIT_SPACE: len_last = shreg[0] ? 4'd2 : 4'd0;
            default:   len_last = 4'd0;
        endcase

        unit_end  = (unit_cnt == UNIT_LAST);
        state_end = unit_end && (unit_num == len_last) && (state != IDLE);

        if (state == IDLE) begin
            env_next = start;
        end else if (state_end) begin
            // SPACE and BIT_SPACE are followed by a mark, every mark by a space
            // (or by idle after STOP).
            env_next = (state == SPACE) || (state == BIT_SPACE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            env      <= 1'b0;
            unit_cnt <= '0;
            unit_num <= '0;
            bit_cnt  <= '0;
            // NOTE: the shift register is reset too; it is a handful of flops,
            // not a memory, and a known value keeps len_last clean after reset.
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            env  <= env_next;

            if (state == IDLE) begin
                if (start) begin
                    shreg    <= data;
                    unit_cnt <= '0;
                    unit_num <= '0;
                    bit_cnt  <= '0;
                    ready    <= 1'b0;
                    state    <= AGC;
                end
            end else if (!unit_end) begin
                unit_cnt <= unit_cnt + 1'b1;
            end else begin
                unit_cnt <= '0;
                if (!state_end) begin
                    unit_num <= unit_num + 1'b1;
                end else begin
                    unit_num <= '0;
                    case (state)
                        AGC:       state <= SPACE;
                        SPACE:     state <= BIT_MARK;
                        BIT_MARK:  state <= BIT_SPACE;
                        BIT_SPACE: begin
                            shreg <= shreg >> 1;
                            if (bit_cnt == 5'd31) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                state   <= BIT_MARK;
                            end
                        end
                        STOP: begin
                            state <= IDLE;
                            ready <= 1'b1;
                            done  <= 1'b1;
                        end
                        default:   state <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef IR_NEC_TX_CARRIER_EN
    localparam int            CW       = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [CW-1:0] CAR_LAST = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] CAR_HIGH = CW'(CARRIER_HIGH);

    logic [CW-1:0] car_cnt;
    logic [CW-1:0] car_next;

    // The counter sits at 0 through every space, so each mark opens on the
    // high phase of the carrier.
    always_comb begin
        car_next = '0;
        if (env_next && env) begin
            car_next = (car_cnt == CAR_LAST) ? '0 : car_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_cnt <= '0;
            ir_out  <= 1'b0;
        end else begin
            car_cnt <= car_next;
            ir_out  <= env_next && (car_next < CAR_HIGH);
        end
    end
`else
    assign ir_out = env;
`endif

endmodule

// File: tb/tb_ir_nec_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ir_nec_tx -- directed bench for ir_nec_tx with UNIT_CYCLES=10,
// CARRIER_DIV=6, CARRIER_HIGH=2. Expected waveforms come from a cycle model of
// the NEC frame built from the payload; frames are also decoded from ir_out.
// -----------------------------------------------------------------------------
module tb_ir_nec_tx;

    localparam int U   = 10;
    localparam int DIV = 6;
    localparam int HI  = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [31:0] data  = '0;
    logic        ready;
    logic        done;
    logic        ir_out;

    int total = 0;
    int bad   = 0;

    ir_nec_tx #(
        .UNIT_CYCLES (U),
        .CARRIER_DIV (DIV),
        .CARRIER_HIGH(HI)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .ready (ready),
        .done  (done),
        .ir_out(ir_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int popcnt(input logic [31:0] d);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(d[i]);
        return n;
    endfunction

    // Expected ir_out in cycle k of a frame whose accept edge is cycle 0.
    function automatic logic exp_ir(input logic [31:0] d, input int k);
        logic env   = 1'b0;
        int   off   = 0;
        int   t;
        int   blen;
        logic found = 1'b0;
        if (k >= 1 && k <= 16*U) begin
            env = 1'b1;
            off = k - 1;
        end else if (k > 24*U) begin
            t = k - 24*U - 1;
            for (int i = 0; i < 32; i++) begin
                blen = d[i] ? 4*U : 2*U;
                if (!found) begin
                    if (t < blen) begin
                        found = 1'b1;
                        if (t < U) begin
                            env = 1'b1;
                            off = t;
                        end
                    end else begin
                        t -= blen;
                    end
                end
            end
            if (!found && t < U) begin
                env = 1'b1;
                off = t;
            end
        end
`ifdef IR_NEC_TX_CARRIER_EN
        return env && ((off % DIV) < HI);
`else
        return env;
`endif
    endfunction

    // Runs one frame. With chained=1 the caller has already raised start at
    // the negedge of the previous done cycle. poke_at>0 pulses start with new
    // data at that cycle of the frame, which must be ignored.
    task automatic run_frame(input string tag, input logic [31:0] d,
                             input logic chained, input int poke_at);
        int          len     = (89 + 2*popcnt(d)) * U;
        int          env_err = 0;
        int          rdy_err = 0;
        int          done_at = 0;
        int          done_n  = 0;
        int          zrun    = 0;
        int          sp      = 0;
        logic [31:0] rx      = '0;
        if (!chained) begin
            @(negedge clk);
            start = 1'b1;
            data  = d;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        data  = 32'hDEAD_BEEF;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            if (ir_out !== exp_ir(d, k)) env_err++;
            if (ready !== (k == len + 1)) rdy_err++;
            if (done === 1'b1) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
            // Pulse-distance decode: zero runs of 8+ cycles are real spaces;
            // the first is the header space, the next 32 carry the bits.
            if (ir_out === 1'b0) begin
                zrun++;
            end else begin
                if (zrun >= 8) begin
                    if (sp > 0 && sp <= 32) rx[sp-1] = (zrun >= 20);
                    sp++;
                end
                zrun = 0;
            end
            if (k == poke_at) begin
                start = 1'b1;
                data  = ~d;
            end else if (k == poke_at + 1) begin
                start = 1'b0;
            end
        end
        check({tag, "_env_errs"},   env_err, 0);
        check({tag, "_ready_errs"}, rdy_err, 0);
        check({tag, "_done_cycle"}, done_at, len + 1);
        check({tag, "_done_count"}, done_n,  1);
        check({tag, "_spaces"},     sp,      33);
        check({tag, "_decoded"},    rx,      d);
    endtask

    initial begin
        int idle_err;
        int late_done;
        int aborts[2];
        aborts[0] = 80;
        aborts[1] = 500;

        // Reset state while rst is held.
        repeat (3) @(negedge clk);
        check("rst_ready",  ready,  1'b1);
        check("rst_done",   done,   1'b0);
        check("rst_ir_out", ir_out, 1'b0);
        rst = 1'b0;

        // Idle for 100 cycles with no request.
        idle_err = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ready !== 1'b1 || done !== 1'b0 || ir_out !== 1'b0) idle_err++;
        end
        check("idle_errs", idle_err, 0);

        run_frame("zeros", 32'h0000_0000, 1'b0, -10);
        run_frame("ones",  32'hFFFF_FFFF, 1'b0, 500);
        run_frame("mix",   32'h00FF_40BF, 1'b0, -10);

        // Back-to-back: start raised during the done cycle of the last frame.
        check("chain_done_now", done, 1'b1);
        start = 1'b1;
        data  = 32'hA5C3_0F81;
        run_frame("chain", 32'hA5C3_0F81, 1'b1, -10);

        // Reset mid-frame: one abort inside the AGC mark, one at cycle 500.
        foreach (aborts[a]) begin
            @(negedge clk);
            start = 1'b1;
            data  = 32'h0000_0000;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (aborts[a]) @(negedge clk);
            check("pre_rst_ir_out", ir_out, exp_ir(32'h0000_0000, aborts[a]));
            check("pre_rst_ready",  ready,  1'b0);
            #2;
            rst = 1'b1;
            #1;
            check("async_rst_ir_out", ir_out, 1'b0);
            check("async_rst_ready",  ready,  1'b1);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            late_done = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done !== 1'b0 || ir_out !== 1'b0 || ready !== 1'b1) late_done++;
            end
            check("post_rst_quiet", late_done, 0);
        end

        run_frame("after_rst", 32'h1234_5678, 1'b0, -10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
